// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bundle: execute-side inputs, hazard controls, and the registered
// memory-stage, flag, forwarding and halt outputs.
interface ex_mem_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          stall_in;
  logic          flush_in;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_alu_result;
  logic          ex_z;
  logic          ex_v;
  logic          ex_n;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_wr;
  logic          ex_mem_rd;
  logic          ex_mem_wr;
  logic [DW-1:0] ex_store_data;

  logic          mem_valid;
  logic [3:0]    mem_opcode;
  logic [DW-1:0] mem_alu_result;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_wr;
  logic          mem_mem_rd;
  logic          mem_mem_wr;
  logic [DW-1:0] mem_store_data;
  logic          flag_z;
  logic          flag_v;
  logic          flag_n;
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
  logic          halted;

  // Upstream side: execute stage plus hazard unit.
  modport master (
    output stall_in, flush_in, ex_valid, ex_opcode, ex_alu_result,
           ex_z, ex_v, ex_n, ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr,
           ex_store_data,
    input  mem_valid, mem_opcode, mem_alu_result, mem_rd, mem_reg_wr,
           mem_mem_rd, mem_mem_wr, mem_store_data, flag_z, flag_v, flag_n,
           fwd_valid, fwd_rd, fwd_data, halted
  );

  // The pipeline register itself.
  modport slave (
    input  stall_in, flush_in, ex_valid, ex_opcode, ex_alu_result,
           ex_z, ex_v, ex_n, ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr,
           ex_store_data,
    output mem_valid, mem_opcode, mem_alu_result, mem_rd, mem_reg_wr,
           mem_mem_rd, mem_mem_wr, mem_store_data, flag_z, flag_v, flag_n,
           fwd_valid, fwd_rd, fwd_data, halted
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural Z/V/N flags, stall/flush
// handling, forwarding from registered state and a sticky halt.
module ex_mem_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic           clk,
  input  logic           rst,
  ex_mem_stage_if.slave  bus
);
  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;
  localparam logic [3:0] OpHlt = 4'b1111;

  logic          memValid_q, memValid_d;
  logic [3:0]    memOpcode_q, memOpcode_d;
  logic [DW-1:0] memResult_q, memResult_d;
  logic [RW-1:0] memRd_q, memRd_d;
  logic          memRegWr_q, memRegWr_d;
  logic          memMemRd_q, memMemRd_d;
  logic          memMemWr_q, memMemWr_d;
  logic [DW-1:0] memStore_q, memStore_d;
  logic          flagZ_q, flagZ_d;
  logic          flagV_q, flagV_d;
  logic          flagN_q, flagN_d;
  logic          halted_q, halted_d;
  logic          cap;

  assign cap = bus.ex_valid & ~bus.stall_in & ~halted_q & ~bus.flush_in;

  // Stall holds everything; otherwise a non-captured edge is a bubble that
  // clears valid and control bits but keeps the data fields.
  always_comb begin
    memValid_d  = memValid_q;
    memOpcode_d = memOpcode_q;
    memResult_d = memResult_q;
    memRd_d     = memRd_q;
    memRegWr_d  = memRegWr_q;
    memMemRd_d  = memMemRd_q;
    memMemWr_d  = memMemWr_q;
    memStore_d  = memStore_q;
    flagZ_d     = flagZ_q;
    flagV_d     = flagV_q;
    flagN_d     = flagN_q;
    halted_d    = halted_q;
    if (!bus.stall_in) begin
      if (cap) begin
        memValid_d  = 1'b1;
        memOpcode_d = bus.ex_opcode;
        memResult_d = bus.ex_alu_result;
        memRd_d     = bus.ex_rd;
        memRegWr_d  = bus.ex_reg_wr;
        memMemRd_d  = bus.ex_mem_rd;
        memMemWr_d  = bus.ex_mem_wr;
        memStore_d  = bus.ex_store_data;
        case (bus.ex_opcode)
          OpAdd, OpSub: begin
            flagZ_d = bus.ex_z;
            flagV_d = bus.ex_v;
            flagN_d = bus.ex_n;
          end
          OpXor, OpSll, OpSra, OpRor: flagZ_d = bus.ex_z;
          default: ;
        endcase
        if (bus.ex_opcode == OpHlt) begin
          halted_d = 1'b1;
        end
      end else begin
        memValid_d = 1'b0;
        memRegWr_d = 1'b0;
        memMemRd_d = 1'b0;
        memMemWr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memValid_q  <= 1'b0;
      memOpcode_q <= '0;
      memResult_q <= '0;
      memRd_q     <= '0;
      memRegWr_q  <= 1'b0;
      memMemRd_q  <= 1'b0;
      memMemWr_q  <= 1'b0;
      memStore_q  <= '0;
      flagZ_q     <= 1'b0;
      flagV_q     <= 1'b0;
      flagN_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      memValid_q  <= memValid_d;
      memOpcode_q <= memOpcode_d;
      memResult_q <= memResult_d;
      memRd_q     <= memRd_d;
      memRegWr_q  <= memRegWr_d;
      memMemRd_q  <= memMemRd_d;
      memMemWr_q  <= memMemWr_d;
      memStore_q  <= memStore_d;
      flagZ_q     <= flagZ_d;
      flagV_q     <= flagV_d;
      flagN_q     <= flagN_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.mem_valid      = memValid_q;
  assign bus.mem_opcode     = memOpcode_q;
  assign bus.mem_alu_result = memResult_q;
  assign bus.mem_rd         = memRd_q;
  assign bus.mem_reg_wr     = memRegWr_q;
  assign bus.mem_mem_rd     = memMemRd_q;
  assign bus.mem_mem_wr     = memMemWr_q;
  assign bus.mem_store_data = memStore_q;
  assign bus.flag_z         = flagZ_q;
  assign bus.flag_v         = flagV_q;
  assign bus.flag_n         = flagN_q;
  assign bus.halted         = halted_q;

  // Loads are excluded: their data only exists after the memory access.
  assign bus.fwd_valid = memValid_q & memRegWr_q & ~memMemRd_q & (memRd_q != '0);
  assign bus.fwd_rd    = memRd_q;
  assign bus.fwd_data  = memResult_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vector table, a stall-stability
// sequence, and randomized traffic against a behavioural model.
module tb_ex_mem_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic clk;
  logic rst;
  ex_mem_stage_if #(.DW(DW), .RW(RW)) bus();

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    string       name;
    logic        rst, stall, flush, valid;
    logic [3:0]  op;
    logic [15:0] res;
    logic        z, v, n;
    logic [3:0]  rd;
    logic        regWr, memRd;
    logic        expValid;
    logic [15:0] expRes;
    logic [2:0]  expFlags;
    logic        expFwd, expHalt;
  } vec_t;

  // Behavioural model state.
  logic        mValid, mRegWr, mMemRd, mMemWr, mZ, mV, mN, mHalted;
  logic [3:0]  mOp, mRd;
  logic [15:0] mRes, mStore;
  logic [2:0]  flagMask [16];

  function automatic vec_t mkVec(string name, logic r, logic s, logic f, logic vl,
                                 logic [3:0] op, logic [15:0] res, logic z, logic v,
                                 logic n, logic [3:0] rd, logic regWr, logic memRd,
                                 logic eV, logic [15:0] eRes, logic [2:0] eFl,
                                 logic eFwd, logic eHalt);
    vec_t t;
    t.name = name; t.rst = r; t.stall = s; t.flush = f; t.valid = vl;
    t.op = op; t.res = res; t.z = z; t.v = v; t.n = n; t.rd = rd;
    t.regWr = regWr; t.memRd = memRd; t.expValid = eV; t.expRes = eRes;
    t.expFlags = eFl; t.expFwd = eFwd; t.expHalt = eHalt;
    return t;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Next model state from the current inputs, following the stage's rules.
  task automatic modelStep();
    if (rst) begin
      mValid = 0; mOp = 0; mRes = 0; mRd = 0; mRegWr = 0; mMemRd = 0;
      mMemWr = 0; mStore = 0; mZ = 0; mV = 0; mN = 0; mHalted = 0;
    end else if (!bus.stall_in) begin
      if (bus.ex_valid && !bus.flush_in && !mHalted) begin
        mValid = 1; mOp = bus.ex_opcode; mRes = bus.ex_alu_result; mRd = bus.ex_rd;
        mRegWr = bus.ex_reg_wr; mMemRd = bus.ex_mem_rd; mMemWr = bus.ex_mem_wr;
        mStore = bus.ex_store_data;
        if (flagMask[bus.ex_opcode][2]) mZ = bus.ex_z;
        if (flagMask[bus.ex_opcode][1]) mV = bus.ex_v;
        if (flagMask[bus.ex_opcode][0]) mN = bus.ex_n;
        if (bus.ex_opcode == 4'hF) mHalted = 1;
      end else begin
        mValid = 0; mRegWr = 0; mMemRd = 0; mMemWr = 0;
      end
    end
  endtask

  task automatic applyStimulus(vec_t t);
    rst               = t.rst;
    bus.stall_in      = t.stall;
    bus.flush_in      = t.flush;
    bus.ex_valid      = t.valid;
    bus.ex_opcode     = t.op;
    bus.ex_alu_result = t.res;
    bus.ex_z          = t.z;
    bus.ex_v          = t.v;
    bus.ex_n          = t.n;
    bus.ex_rd         = t.rd;
    bus.ex_reg_wr     = t.regWr;
    bus.ex_mem_rd     = t.memRd;
    bus.ex_mem_wr     = 1'b0;
    bus.ex_store_data = t.res ^ 16'h5A5A;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(vec_t t);
    checkOutput({t.name, ".valid"}, 32'(bus.mem_valid), 32'(t.expValid));
    checkOutput({t.name, ".result"}, 32'(bus.mem_alu_result), 32'(t.expRes));
    checkOutput({t.name, ".flags"}, 32'({bus.flag_z, bus.flag_v, bus.flag_n}), 32'(t.expFlags));
    checkOutput({t.name, ".fwd"}, 32'(bus.fwd_valid), 32'(t.expFwd));
    checkOutput({t.name, ".halted"}, 32'(bus.halted), 32'(t.expHalt));
  endtask

  task automatic checkModel(int cyc);
    string tag;
    logic  expFwd;
    tag = $sformatf("rand%0d", cyc);
    expFwd = mValid && mRegWr && !mMemRd && (mRd != 0);
    checkOutput({tag, ".valid"}, 32'(bus.mem_valid), 32'(mValid));
    checkOutput({tag, ".opcode"}, 32'(bus.mem_opcode), 32'(mOp));
    checkOutput({tag, ".result"}, 32'(bus.mem_alu_result), 32'(mRes));
    checkOutput({tag, ".rd"}, 32'(bus.mem_rd), 32'(mRd));
    checkOutput({tag, ".ctrl"}, 32'({bus.mem_reg_wr, bus.mem_mem_rd, bus.mem_mem_wr}),
                32'({mRegWr, mMemRd, mMemWr}));
    checkOutput({tag, ".store"}, 32'(bus.mem_store_data), 32'(mStore));
    checkOutput({tag, ".flags"}, 32'({bus.flag_z, bus.flag_v, bus.flag_n}), 32'({mZ, mV, mN}));
    checkOutput({tag, ".fwdValid"}, 32'(bus.fwd_valid), 32'(expFwd));
    checkOutput({tag, ".fwdRd"}, 32'(bus.fwd_rd), 32'(mRd));
    checkOutput({tag, ".fwdData"}, 32'(bus.fwd_data), 32'(mRes));
    checkOutput({tag, ".halted"}, 32'(bus.halted), 32'(mHalted));
  endtask

  vec_t vecs [17];

  initial begin
    vec_t t;
    // Which flags each opcode writes, as {Z,V,N}.
    for (int i = 0; i < 16; i++) flagMask[i] = 3'b000;
    flagMask[0] = 3'b111; flagMask[1] = 3'b111;
    flagMask[2] = 3'b100; flagMask[4] = 3'b100; flagMask[5] = 3'b100; flagMask[6] = 3'b100;

    //                  name       rst st fl vl op    res       z v n rd rw mr  eV eRes      eFl     eF eH
    vecs[0]  = mkVec("reset",     1, 0, 0, 0, 4'h0, 16'h0000, 0,0,0, 0, 0,0,  0, 16'h0000, 3'b000, 0, 0);
    vecs[1]  = mkVec("addZero",   0, 0, 0, 1, 4'h0, 16'h0000, 1,1,0, 3, 1,0,  1, 16'h0000, 3'b110, 1, 0);
    vecs[2]  = mkVec("paddsub",   0, 0, 0, 1, 4'h7, 16'h7F7F, 0,0,0, 3, 1,0,  1, 16'h7F7F, 3'b110, 1, 0);
    vecs[3]  = mkVec("addNeg",    0, 0, 0, 1, 4'h0, 16'h8000, 0,0,1, 2, 1,0,  1, 16'h8000, 3'b001, 1, 0);
    vecs[4]  = mkVec("xorZonly",  0, 0, 0, 1, 4'h2, 16'h1234, 0,1,1, 2, 1,0,  1, 16'h1234, 3'b001, 1, 0);
    vecs[5]  = mkVec("stallFl1",  0, 1, 1, 1, 4'h1, 16'h0001, 1,1,0, 4, 1,0,  1, 16'h1234, 3'b001, 1, 0);
    vecs[6]  = mkVec("stallFl2",  0, 1, 1, 1, 4'h1, 16'h0001, 1,1,0, 4, 1,0,  1, 16'h1234, 3'b001, 1, 0);
    vecs[7]  = mkVec("subRel",    0, 0, 0, 1, 4'h1, 16'h0001, 1,1,0, 4, 1,0,  1, 16'h0001, 3'b110, 1, 0);
    vecs[8]  = mkVec("flushAdd",  0, 0, 1, 1, 4'h0, 16'h5555, 0,0,0, 1, 1,0,  0, 16'h0001, 3'b110, 0, 0);
    vecs[9]  = mkVec("lwNoFwd",   0, 0, 0, 1, 4'h8, 16'h2000, 0,0,0, 5, 1,1,  1, 16'h2000, 3'b110, 0, 0);
    vecs[10] = mkVec("addRd0",    0, 0, 0, 1, 4'h0, 16'h0042, 0,0,1, 0, 1,0,  1, 16'h0042, 3'b001, 0, 0);
    vecs[11] = mkVec("bubble",    0, 0, 0, 0, 4'h0, 16'h9999, 1,1,1, 1, 1,0,  0, 16'h0042, 3'b001, 0, 0);
    vecs[12] = mkVec("hlt",       0, 0, 0, 1, 4'hF, 16'h00FF, 0,0,0, 0, 0,0,  1, 16'h00FF, 3'b001, 0, 1);
    vecs[13] = mkVec("postHlt1",  0, 0, 0, 1, 4'h0, 16'h7777, 1,1,1, 6, 1,0,  0, 16'h00FF, 3'b001, 0, 1);
    vecs[14] = mkVec("postHlt2",  0, 0, 0, 1, 4'h0, 16'h7777, 1,1,1, 6, 1,0,  0, 16'h00FF, 3'b001, 0, 1);
    vecs[15] = mkVec("rstStall",  1, 1, 1, 1, 4'h0, 16'h7777, 1,1,1, 6, 1,0,  0, 16'h0000, 3'b000, 0, 0);
    vecs[16] = mkVec("resume",    0, 0, 0, 1, 4'h0, 16'h0003, 0,1,0, 7, 1,0,  1, 16'h0003, 3'b010, 1, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end

    // Three stall cycles: outputs stay at the captured ADD for four cycles total.
    t = mkVec("stlCap", 0, 0, 0, 1, 4'h0, 16'hABCD, 0,0,1, 2, 1,0, 1, 16'hABCD, 3'b001, 1, 0);
    applyStimulus(t);
    checkVector(t);
    for (int k = 0; k < 3; k++) begin
      t = mkVec($sformatf("stlHold%0d", k), 0, 1, k[0], 1, 4'h1, 16'h1111, 1,1,0, 9, 1,0,
                1, 16'hABCD, 3'b001, 1, 0);
      applyStimulus(t);
      checkVector(t);
    end
    t = mkVec("stlRelBub", 0, 0, 0, 0, 4'h1, 16'h1111, 1,1,0, 9, 1,0, 0, 16'hABCD, 3'b001, 0, 0);
    applyStimulus(t);
    checkVector(t);

    // Randomized traffic, starting from a known reset.
    rst = 1'b1;
    modelStep();
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      rst               = ($urandom_range(0, 99) < 3);
      bus.stall_in      = ($urandom_range(0, 99) < 15);
      bus.flush_in      = ($urandom_range(0, 99) < 10);
      bus.ex_valid      = ($urandom_range(0, 99) < 85);
      bus.ex_opcode     = 4'($urandom_range(0, 15));
      if (bus.ex_opcode == 4'hF && $urandom_range(0, 3) != 0) bus.ex_opcode = 4'h0;
      bus.ex_alu_result = 16'($urandom);
      bus.ex_z          = 1'($urandom);
      bus.ex_v          = 1'($urandom);
      bus.ex_n          = 1'($urandom);
      bus.ex_rd         = 4'($urandom);
      bus.ex_reg_wr     = 1'($urandom);
      bus.ex_mem_rd     = 1'($urandom);
      bus.ex_mem_wr     = 1'($urandom);
      bus.ex_store_data = 16'($urandom);
      modelStep();
      @(posedge clk);
      #1;
      checkModel(c);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline register with the architectural flag register. It sits directly downstream of the execute-stage ALU, including the saturating nibble adder, and registers each ALU result with its control bits for the memory stage. It commits Z/V/N flags according to the per-opcode update rules, honours stall and flush from the hazard unit, and provides forwarding data and a sticky halt indication.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 4, register index width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous and active-high
- stall_in  in  1  holds all state
- flush_in  in  1  squashes the EX instruction
- ex_valid  in  1  EX slot holds a real instruction
- ex_opcode  in  4  instruction opcode
- ex_alu_result  in  DW  ALU output (PADDSUB result already saturated)
- ex_z, ex_v, ex_n  in  1 each  ALU flag candidates
- ex_rd  in  RW  destination register
- ex_reg_wr, ex_mem_rd, ex_mem_wr  in  1 each  control bits
- ex_store_data  in  DW  SW data
- mem_valid  out  1  registered valid
- mem_opcode  out  4  registered opcode
- mem_alu_result  out  DW  registered result / address
- mem_rd  out  RW  registered destination register
- mem_reg_wr, mem_mem_rd, mem_mem_wr  out  1 each  registered control bits
- mem_store_data  out  DW  registered SW data
- flag_z, flag_v, flag_n  out  1 each  architectural flags, to the branch unit
- fwd_valid  out  1  forwarding source is valid
- fwd_rd  out  RW  forwarding register index
- fwd_data  out  DW  forwarding data
- halted  out  1  sticky HLT indication

## Operation
- Opcodes:
  - ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSUB=0111
  - LW=1000, SW=1001, LLB=1010, LHB=1011, B=1100, BR=1101, PCS=1110, HLT=1111
- Capture condition: `cap = ex_valid & ~stall_in & ~halted & ~flush_in`.
- Per-edge priority: rst > stall_in > flush_in > capture.
  - **stall_in=1:** every register, flag and halted holds, even when flush_in=1 in the same cycle. The flush is re-asserted by the hazard unit after the stall releases.
  - **flush_in=1 (no stall):** mem_valid←0 and all mem_* control bits←0. Data fields are don't-care and are held. Flags are unchanged.
  - **ex_valid=0 (no stall/flush):** same effect as flush, i.e. a bubble.
  - **halted=1:** the stage behaves as a permanent bubble. mem_valid←0 on every edge and flags are frozen until rst.
- On cap, all mem_* fields are loaded from the ex_* fields and mem_valid←1.
- Flag commit happens on the same edge as cap:
  - ADD, SUB: Z←ex_z, V←ex_v, N←ex_n.
  - XOR, SLL, SRA, ROR: Z←ex_z; V and N hold.
  - RED, PADDSUB, memory, load-immediate, branch, PCS and HLT opcodes: no flag change.
- Halt: cap with opcode HLT sets halted←1. The HLT itself is registered with mem_valid=1.
- Forwarding (combinational from registered state only; no ex_* input feeds any output combinationally):
  - fwd_valid = mem_valid & mem_reg_wr & ~mem_mem_rd & (mem_rd≠0).
  - fwd_rd = mem_rd.
  - fwd_data = mem_alu_result.
  - LW results are never forwarded from this stage.

## Timing
- Reset values (one edge with rst=1): every output is 0, including mem_valid, all control bits, data fields, flags, halted and fwd_valid.
- Latency:
  - ex_* visible on mem_* one edge after cap.
  - Flags updated on that same edge.
  - A branch resolving in the following cycle sees the new flags.
- Back-to-back: consecutive caps update the stage on every edge with no gap.
- Flag-writing instruction followed by a bubble or flush: flags keep the last committed value.
- Stall for N cycles: the mem_* outputs are stable for N+1 cycles counting the original capture cycle.
- Reset mid-stream: it overrides stall, flush and halted in the same edge. Operation resumes the cycle after rst deasserts.

## Test plan
1. Reset, then cap ADD with result 0x0000, ex_z=1, ex_v=1, ex_n=0 → next edge: mem_alu_result=0x0000, flags Z=1, V=1, N=0, fwd_valid=1 for rd=3.
2. After scenario 1, cap PADDSUB with result 0x7F7F and all ex flags 0 → flags remain Z=1, V=1, N=0; mem_alu_result=0x7F7F.
3. Cap XOR with ex_z=0, ex_v=1, ex_n=1 following an ADD that set V=0, N=1 → Z=0, V=0, N=1.
4. Cap SUB while stall_in=1 and flush_in=1 for 2 cycles, then release → mem_* and flags unchanged for both cycles; the SUB is captured on the release edge.
5. Flush a valid ADD → mem_valid=0, fwd_valid=0, flags unchanged. LW with rd=5 → fwd_valid=0. ADD with rd=0 → fwd_valid=0.
6. Cap HLT, then present a valid ADD → halted=1, the HLT is registered with mem_valid=1, then mem_valid=0 with flags frozen. Asserting rst clears halted to 0.
